sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 24 ++
 rtl/sram_arbiter_arb_pick.sv | 53 +++++
 rtl/sram_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
// Module      : sram_arbiter_pkg
// Description : Shared constants for the SRAM arbiter: FSM state encodings
//               and transaction-owner encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arbiter_pkg;

  // Arbiter FSM: one transaction outstanding at most
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no transaction, arbitrating
    ADDR = 2'd1,  // request issued, waiting for mem_addr_ok
    RESP = 2'd2   // address accepted, waiting for mem_data_ok
  } state_t;

  // Owner of the shared memory port
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_arb_pick.sv
// ============================================================================
// Module      : arb_pick
// Description : Winner selection between fetch and load/store requesters.
//               Macro ARB_RR_EN selects round-robin (grant goes to the side
//               not granted last); otherwise fixed priority, data over inst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic i_inst_req,
  input  logic i_data_req,
  input  logic i_grant,     // a grant is being made this cycle
  output logic o_winner     // OWN_INST or OWN_DATA
);

`ifdef ARB_RR_EN
  logic r_last_grant;

  // On contention favour the requester that was not granted last
  always_comb begin
    o_winner = OWN_INST;
    if (i_inst_req && i_data_req) begin
      o_winner = (r_last_grant == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (i_data_req) begin
      o_winner = OWN_DATA;
    end
  end

  // Remember who won every grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= OWN_DATA;
    end else if (i_grant) begin
      r_last_grant <= o_winner;
    end
  end
`else
  // Fixed priority: a pending load/store always wins
  assign o_winner = i_data_req ? OWN_DATA : OWN_INST;

  // History-free selection leaves these inputs without a load
  logic w_unused;
  assign w_unused = &{1'b0, clk, resetn, i_inst_req, i_grant};
`endif

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module      : sram_arbiter
// Description : Arbitrates a fetch port and a load/store port onto a single
//               SRAM-like memory port, one transaction in flight at a time.
//               Optional macro ARB_RR_EN enables round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  // fetch requester
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // load/store requester
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // shared memory port
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  // stall feedback
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  state_t r_state;
  logic   r_owner;

  logic w_any;
  logic w_grant;
  logic w_winner;
  logic w_sel;
  logic w_issue;
  logic w_resp;

  assign w_any   = inst_req | data_req;
  assign w_grant = (r_state == IDLE) && w_any;

  arb_pick u_arb_pick (
    .clk        (clk),
    .resetn     (resetn),
    .i_inst_req (inst_req),
    .i_data_req (data_req),
    .i_grant    (w_grant),
    .o_winner   (w_winner)
  );

  // In IDLE the fresh winner drives the port; afterwards the latched owner does
  assign w_sel   = (r_state == IDLE) ? w_winner : r_owner;
  // Gate with resetn so nothing handshakes while reset is held
  assign w_issue = resetn && (w_grant || (r_state == ADDR));
  assign w_resp  = resetn && (r_state == RESP) && mem_data_ok;

  assign mem_req = w_issue;

  // Route the selected requester's fields; a fetch never writes
  always_comb begin
    mem_addr  = inst_addr;
    mem_wr    = 1'b0;
    mem_wstrb = {STRB_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (w_sel == OWN_DATA) begin
      mem_addr  = data_addr;
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = w_issue && (w_sel == OWN_INST) && mem_addr_ok;
  assign data_addr_ok = w_issue && (w_sel == OWN_DATA) && mem_addr_ok;
  assign inst_data_ok = w_resp && (r_owner == OWN_INST);
  assign data_data_ok = w_resp && (r_owner == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = (r_state != IDLE);

  // Transaction FSM: issue, wait for address acceptance, wait for data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_owner <= OWN_DATA;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_state <= mem_addr_ok ? RESP : ADDR;
          end
        end
        ADDR: begin
          if (mem_addr_ok) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (mem_data_ok) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
